// File: rtl/usb_pkg.sv
// Shared USB definitions for the serial function.
// Contents: full-speed bulk packet limit and the bulk IN endpoint state encoding.
package usb_pkg;

  localparam int unsigned USB_FS_MAX_BULK_PKT = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_FILL     = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT_ACK = 3'd4
  } ep_state_e;

endpackage

// File: rtl/usb_byte_fifo.sv
// Synchronous byte FIFO staging device-to-host data.
// Ports: clk, reset_n (async active-low); wr_en_i/wr_data_i write side (ignored when full);
//        rd_en_i read side (ignored when empty); rd_data_o head of queue (combinational);
//        empty_o, full_o status.
module usb_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             wr_fire, rd_fire;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_fire   = wr_en_i && !full_o;
  assign rd_fire   = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_fire) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/usb_serial_bulk_in_ep.sv
// Bulk IN endpoint: packs the device-to-host byte stream into USB bulk packets.
// Ports: clk, reset_n (async active-low);
//        uart_in_data/valid/ready  byte stream from the device (ready = FIFO not full);
//        in_ep_req/grant           PE IN-buffer arbitration;
//        in_ep_data_free/put/data  byte transfer into the PE buffer (put and data combinational);
//        in_ep_data_done           one-cycle packet-complete pulse;
//        in_ep_stall               tied low; in_ep_acked host ACK of the last packet.
module usb_serial_bulk_in_ep
  import usb_pkg::*;
#(
  parameter int unsigned MAX_PKT      = USB_FS_MAX_BULK_PKT,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned FLUSH_CYCLES = 48000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] uart_in_data,
  input  logic       uart_in_valid,
  output logic       uart_in_ready,
  output logic       in_ep_req,
  input  logic       in_ep_grant,
  input  logic       in_ep_data_free,
  output logic       in_ep_data_put,
  output logic [7:0] in_ep_data,
  output logic       in_ep_data_done,
  output logic       in_ep_stall,
  input  logic       in_ep_acked
);

  localparam int unsigned CNT_W = $clog2(MAX_PKT + 1);
  localparam int unsigned TMR_W = $clog2(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] PKT_FULL = CNT_W'(MAX_PKT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FLUSH_CYCLES - 1);

  ep_state_e        state_q, state_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             zlp_pending_q, zlp_pending_d;
  logic             req_q, done_q;
  logic             fifo_empty, fifo_full, put_c;

  usb_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (uart_in_valid),
    .wr_data_i (uart_in_data),
    .rd_en_i   (put_c),
    .rd_data_o (in_ep_data),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  // Grant comes combinationally from the PE, so the put strobe must too.
  assign put_c = (state_q == ST_FILL) && in_ep_grant && in_ep_data_free &&
                 !fifo_empty && (pkt_cnt_q < PKT_FULL);

  assign uart_in_ready   = !fifo_full;
  assign in_ep_data_put  = put_c;
  assign in_ep_req       = req_q;
  assign in_ep_data_done = done_q;
  assign in_ep_stall     = 1'b0;

  // Next-state, packet count and flush timer.
  always_comb begin
    state_d       = state_q;
    pkt_cnt_d     = pkt_cnt_q;
    timer_d       = timer_q;
    zlp_pending_d = zlp_pending_q;
    unique case (state_q)
      ST_IDLE: begin
        pkt_cnt_d = '0;
        timer_d   = '0;
        if (!fifo_empty || zlp_pending_q) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (in_ep_grant) state_d = ST_FILL;
      end
      ST_FILL: begin
        // Without grant the PE is not listening: everything holds.
        if (in_ep_grant) begin
          if (put_c) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            timer_d   = '0;
          end else if (timer_q != TMR_LAST) begin
            timer_d = timer_q + TMR_W'(1);
          end
          // Decide on next values so done follows the last put by one cycle.
          if ((pkt_cnt_d == PKT_FULL) ||
              ((timer_d == TMR_LAST) && ((pkt_cnt_d != '0) || zlp_pending_q))) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // A full packet leaves a ZLP owed; any shorter packet (incl. the ZLP) settles it.
        zlp_pending_d = (pkt_cnt_q == PKT_FULL);
        state_d       = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (in_ep_acked) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pkt_cnt_q     <= '0;
      timer_q       <= '0;
      zlp_pending_q <= 1'b0;
      req_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pkt_cnt_q     <= pkt_cnt_d;
      timer_q       <= timer_d;
      zlp_pending_q <= zlp_pending_d;
      req_q         <= (state_d != ST_IDLE);
      done_q        <= (state_d == ST_DONE);
    end
  end

endmodule
